// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath widths, MEM/WB FSM states and the
// writeback control bundle carried alongside an outstanding memory access.
package pipeline_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    // Writeback control fields that travel with an instruction into WB.
    typedef struct packed {
        logic             RegWrite;
        logic             MemtoReg;
        logic [REG_W-1:0] WriteReg;
    } mem_wb_ctrl_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Clear/enable cycle counter that flags expiry once it reaches TIMEOUT-1.
// Used to bound how long a memory request may wait for its acknowledge.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] cnt_r;

    // Count waiting cycles; clear has priority over enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 8'd0;
        end else if (clear) begin
            cnt_r <= 8'd0;
        end else if (enable) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_wb_control.sv
// MEM->WB sequencing: issues loads/stores to a variable-latency memory over
// a req/ack handshake, stalls upstream while an access is outstanding and
// presents registered writeback fields to the result mux and register file.
import pipeline_pkg::*;

module mem_wb_control #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic [REG_W-1:0]  WriteReg_in,
    input  logic [DATA_W-1:0] ALUresult_in,
    input  logic [DATA_W-1:0] WriteData_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              RegWrite,
    output logic              MemtoReg,
    output logic [REG_W-1:0]  WriteReg,
    output logic [DATA_W-1:0] ALUresult,
    output logic [DATA_W-1:0] ReadData,
    output logic              mem_error
);

    mem_state_t        state_r,     state_s;
    mem_wb_ctrl_t      pend_ctrl_r, pend_ctrl_s;
    logic              pend_load_r, pend_load_s;
    logic              mem_req_r,   mem_req_s;
    logic              mem_we_r,    mem_we_s;
    logic [DATA_W-1:0] mem_addr_r,  mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic              wb_valid_r,  wb_valid_s;
    logic              regwrite_r,  regwrite_s;
    logic              memtoreg_r,  memtoreg_s;
    logic [REG_W-1:0]  writereg_r,  writereg_s;
    logic [DATA_W-1:0] aluresult_r, aluresult_s;
    logic [DATA_W-1:0] readdata_r,  readdata_s;
    logic              mem_error_r, mem_error_s;

    logic              waiting_s;
    logic              cnt_clear_s;
    logic              cnt_enable_s;
    logic              expired_s;

    assign waiting_s    = (state_r == MEM_WAIT);
    assign cnt_clear_s  = ~waiting_s | mem_ack;
    assign cnt_enable_s = waiting_s & ~mem_ack & ~expired_s;

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear_s),
        .enable  (cnt_enable_s),
        .expired (expired_s)
    );

    // Next-state and next-output computation; every register holds by default.
    always_comb begin
        state_s     = state_r;
        pend_ctrl_s = pend_ctrl_r;
        pend_load_s = pend_load_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        wb_valid_s  = wb_valid_r;
        regwrite_s  = regwrite_r;
        memtoreg_s  = memtoreg_r;
        writereg_s  = writereg_r;
        aluresult_s = aluresult_r;
        readdata_s  = readdata_r;
        mem_error_s = mem_error_r;

        case (state_r)
            IDLE: begin
                if (valid_in && (MemRead_in || MemWrite_in)) begin
                    // A load wins when both MemRead and MemWrite are set.
                    state_s              = MEM_WAIT;
                    mem_req_s            = 1'b1;
                    mem_we_s             = MemWrite_in & ~MemRead_in;
                    mem_addr_s           = ALUresult_in;
                    mem_wdata_s          = WriteData_in;
                    pend_load_s          = MemRead_in;
                    pend_ctrl_s.RegWrite = RegWrite_in;
                    pend_ctrl_s.MemtoReg = MemtoReg_in;
                    pend_ctrl_s.WriteReg = WriteReg_in;
                    wb_valid_s           = 1'b0;
                    regwrite_s           = 1'b0;
                end else if (valid_in) begin
                    wb_valid_s  = 1'b1;
                    regwrite_s  = RegWrite_in;
                    memtoreg_s  = MemtoReg_in;
                    writereg_s  = WriteReg_in;
                    aluresult_s = ALUresult_in;
                end else begin
                    wb_valid_s = 1'b0;
                    regwrite_s = 1'b0;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_s     = IDLE;
                    mem_req_s   = 1'b0;
                    mem_we_s    = 1'b0;
                    wb_valid_s  = 1'b1;
                    writereg_s  = pend_ctrl_r.WriteReg;
                    aluresult_s = mem_addr_r;
                    if (pend_load_r) begin
                        readdata_s = mem_rdata;
                        memtoreg_s = 1'b1;
                        regwrite_s = pend_ctrl_r.RegWrite;
                    end else begin
                        memtoreg_s = pend_ctrl_r.MemtoReg;
                        regwrite_s = 1'b0;
                    end
                end else if (expired_s) begin
                    // Give up: retire without a register write and flag it.
                    state_s     = IDLE;
                    mem_req_s   = 1'b0;
                    mem_we_s    = 1'b0;
                    mem_error_s = 1'b1;
                    wb_valid_s  = 1'b1;
                    regwrite_s  = 1'b0;
                    memtoreg_s  = pend_ctrl_r.MemtoReg;
                    writereg_s  = pend_ctrl_r.WriteReg;
                    aluresult_s = mem_addr_r;
                end else begin
                    wb_valid_s = 1'b0;
                    regwrite_s = 1'b0;
                end
            end
            default: begin
                state_s    = IDLE;
                mem_req_s  = 1'b0;
                mem_we_s   = 1'b0;
                wb_valid_s = 1'b0;
                regwrite_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset to all-zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            pend_ctrl_r <= '0;
            pend_load_r <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            wb_valid_r  <= 1'b0;
            regwrite_r  <= 1'b0;
            memtoreg_r  <= 1'b0;
            writereg_r  <= '0;
            aluresult_r <= '0;
            readdata_r  <= '0;
            mem_error_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            pend_ctrl_r <= pend_ctrl_s;
            pend_load_r <= pend_load_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            wb_valid_r  <= wb_valid_s;
            regwrite_r  <= regwrite_s;
            memtoreg_r  <= memtoreg_s;
            writereg_r  <= writereg_s;
            aluresult_r <= aluresult_s;
            readdata_r  <= readdata_s;
            mem_error_r <= mem_error_s;
        end
    end

    assign stall     = waiting_s;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign wb_valid  = wb_valid_r;
    assign RegWrite  = regwrite_r;
    assign MemtoReg  = memtoreg_r;
    assign WriteReg  = writereg_r;
    assign ALUresult = aluresult_r;
    assign ReadData  = readdata_r;
    assign mem_error = mem_error_r;

endmodule

// File: tb/tb_mem_wb_control.sv
// Directed bench for mem_wb_control: a scoreboard queue holds the expected
// writeback of each instruction and is checked whenever wb_valid is seen.
module tb_mem_wb_control;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in, MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in;
    logic [RW-1:0] WriteReg_in;
    logic [DW-1:0] ALUresult_in, WriteData_in;
    logic          stall, mem_req, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          wb_valid, RegWrite, MemtoReg;
    logic [RW-1:0] WriteReg;
    logic [DW-1:0] ALUresult, ReadData;
    logic          mem_error;

    typedef struct {
        logic          rw;
        logic          m2r;
        logic [RW-1:0] wr;
        logic [DW-1:0] alu;
        logic [DW-1:0] rd;
    } wb_exp_t;

    wb_exp_t sb[$];
    int      n_cmp = 0;
    int      n_err = 0;

    mem_wb_control #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .WriteReg_in(WriteReg_in), .ALUresult_in(ALUresult_in),
        .WriteData_in(WriteData_in), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .WriteReg(WriteReg),
        .ALUresult(ALUresult), .ReadData(ReadData), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic mr, input logic mw, input logic rw,
                         input logic m2r, input logic [RW-1:0] wr,
                         input logic [DW-1:0] alu, input logic [DW-1:0] wd);
        valid_in = v; MemRead_in = mr; MemWrite_in = mw; RegWrite_in = rw;
        MemtoReg_in = m2r; WriteReg_in = wr; ALUresult_in = alu; WriteData_in = wd;
    endtask

    task automatic push(input logic rw, input logic m2r, input logic [RW-1:0] wr,
                        input logic [DW-1:0] alu, input logic [DW-1:0] rd);
        wb_exp_t e;
        e.rw = rw; e.m2r = m2r; e.wr = wr; e.alu = alu; e.rd = rd;
        sb.push_back(e);
    endtask

    // Writeback monitor: every retiring instruction must match the queue head.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            check("wb_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                wb_exp_t e;
                e = sb.pop_front();
                check("wb_RegWrite",  64'(RegWrite),  64'(e.rw));
                check("wb_MemtoReg",  64'(MemtoReg),  64'(e.m2r));
                check("wb_WriteReg",  64'(WriteReg),  64'(e.wr));
                check("wb_ALUresult", 64'(ALUresult), 64'(e.alu));
                check("wb_ReadData",  64'(ReadData),  64'(e.rd));
            end
        end
    end

    initial begin
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick(); tick();

        // Reset state
        check("rst_stall",     64'(stall),     64'd0);
        check("rst_mem_req",   64'(mem_req),   64'd0);
        check("rst_wb_valid",  64'(wb_valid),  64'd0);
        check("rst_mem_error", 64'(mem_error), 64'd0);
        check("rst_ALUresult", 64'(ALUresult), 64'd0);
        reset = 1'b0;

        // ALU op
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h0000_00A5, 32'h0);
        push(1'b1, 1'b0, 5'd3, 32'h0000_00A5, 32'h0);
        tick();
        check("alu_stall", 64'(stall), 64'd0);
        check("alu_wb_valid", 64'(wb_valid), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        check("idle_wb_valid", 64'(wb_valid), 64'd0);
        check("idle_RegWrite", 64'(RegWrite), 64'd0);

        // Load, ack in the third request cycle
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h0000_0100, 32'h0);
        push(1'b1, 1'b1, 5'd7, 32'h0000_0100, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("ld_stall",    64'(stall),    64'd1);
            check("ld_mem_req",  64'(mem_req),  64'd1);
            check("ld_mem_we",   64'(mem_we),   64'd0);
            check("ld_mem_addr", 64'(mem_addr), 64'h100);
            check("ld_wb_valid", 64'(wb_valid), 64'd0);
            if (i == 2) begin
                mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
            end
            tick();
        end
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("ld_done_stall",   64'(stall),   64'd0);
        check("ld_done_mem_req", 64'(mem_req), 64'd0);

        // Store with immediate ack; RegWrite_in set but must be suppressed
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_0040, 32'h0000_1234);
        push(1'b0, 1'b0, 5'd9, 32'h0000_0040, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        check("st_mem_req",   64'(mem_req),   64'd1);
        check("st_mem_we",    64'(mem_we),    64'd1);
        check("st_mem_addr",  64'(mem_addr),  64'h40);
        check("st_mem_wdata", 64'(mem_wdata), 64'h1234);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("st_done_mem_we", 64'(mem_we),  64'd0);
        check("st_done_req",    64'(mem_req), 64'd0);
        check("st_done_stall",  64'(stall),   64'd0);

        // Load that times out after TIMEOUT=4 request cycles
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0200, 32'h0);
        push(1'b0, 1'b1, 5'd4, 32'h0000_0200, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("to_mem_req",   64'(mem_req),   64'd1);
            check("to_mem_error", 64'(mem_error), 64'd0);
            tick();
        end
        check("to_req_drop", 64'(mem_req),   64'd0);
        check("to_stall",    64'(stall),     64'd0);
        check("to_error",    64'(mem_error), 64'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h0000_0077, 32'h0);
        push(1'b1, 1'b0, 5'd5, 32'h0000_0077, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        check("to_error_sticky", 64'(mem_error), 64'd1);
        check("to_alu_stall",    64'(stall),     64'd0);
        tick();

        // Reset in the second MEM_WAIT cycle abandons the access
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h0000_0300, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        check("rs_pre_stall", 64'(stall), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rs_stall",     64'(stall),     64'd0);
        check("rs_mem_req",   64'(mem_req),   64'd0);
        check("rs_mem_we",    64'(mem_we),    64'd0);
        check("rs_mem_addr",  64'(mem_addr),  64'd0);
        check("rs_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rs_wb_valid",  64'(wb_valid),  64'd0);
        check("rs_RegWrite",  64'(RegWrite),  64'd0);
        check("rs_MemtoReg",  64'(MemtoReg),  64'd0);
        check("rs_WriteReg",  64'(WriteReg),  64'd0);
        check("rs_ALUresult", 64'(ALUresult), 64'd0);
        check("rs_ReadData",  64'(ReadData),  64'd0);
        check("rs_mem_error", 64'(mem_error), 64'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0BAD;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("late_ack_wb_valid", 64'(wb_valid), 64'd0);
        check("late_ack_ReadData", 64'(ReadData), 64'd0);
        check("late_ack_stall",    64'(stall),    64'd0);

        // Back-to-back loads; the second is held upstream during the first
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h0000_0500, 32'h0);
        push(1'b1, 1'b1, 5'd10, 32'h0000_0500, 32'h1111_1111);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'h0000_0504, 32'h0);
        push(1'b1, 1'b1, 5'd11, 32'h0000_0504, 32'h2222_2222);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("b2b_gap_req",   64'(mem_req), 64'd0);
        check("b2b_gap_stall", 64'(stall),   64'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        check("b2b_req2",  64'(mem_req),  64'd1);
        check("b2b_addr2", 64'(mem_addr), 64'h504);
        mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
        tick();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
